surf_cout_autotrain: RTL
========================

# surf_cout_autotrain

Sequencer for automatic COUT link alignment on one SURF port, running in the sysclk domain beside the per-SURF COUT/DOUT PHY. On a start request it resets the ISERDES, sweeps the COUT IDELAY across all 64 taps to find the widest window in which the received word is a stable rotation of the training sequence, and parks the delay at that window's centre. It then issues bitslips until the received word equals the training sequence exactly, and reports eye start, width and slip count to the register core.

## Interface
Parameters:
- TRAIN_SEQUENCE, 32'hA55A6996, expected COUT training word.
- RST_CYCLES, 16, ISERDES reset pulse length in clocks.
- SETTLE_CYCLES, 32, wait after each IDELAY load or bitslip.
- SAMPLES, 8, cout_valid words checked per tap.
- BITSLIP_MAX, 32, bitslips attempted before failing.

Ports:
- sysclk_i  in  1  sole clock.
- sysclk_rst_i  in  1  reset; synchronous and active-high.
- start_i  in  1  begin training; ignored while busy_o=1.
- abort_i  in  1  abandon training; return to IDLE.
- cout_data_i  in  32  received COUT word.
- cout_valid_i  in  1  cout_data_i qualifier.
- iserdes_rst_o  out  1  ISERDES reset.
- idelay_value_o  out  6  IDELAY tap value.
- idelay_load_o  out  1  one-cycle IDELAY load strobe.
- bitslip_o  out  1  one-cycle ISERDES bitslip strobe.
- busy_o  out  1  high in every state except IDLE, DONE and ERROR.
- done_o  out  1  alignment succeeded; held until the next start.
- err_o  out  2  0 = none, 1 = no good tap, 2 = bitslip exhausted, 3 = aborted.
- eye_start_o  out  6  first tap of the chosen window.
- eye_width_o  out  7  chosen window width, 0–64.
- bitslip_count_o  out  6  bitslips issued.

## Operation
- Reset: every output is 0 and the state is IDLE.
- IDLE/DONE/ERROR + start_i: clear done_o, err_o, eye_start_o, eye_width_o, bitslip_count_o and the tap counter, then go to RESET.
- RESET: iserdes_rst_o=1 for exactly RST_CYCLES clocks, then LOAD.
- LOAD: drive idelay_value_o=tap and pulse idelay_load_o, then SETTLE.
- SETTLE: wait SETTLE_CYCLES clocks, then SAMPLE.
- SAMPLE:
  - Latch the first valid word as the reference.
  - The tap is good iff all SAMPLES valid words equal the reference AND the reference equals some 1-bit left rotation (0..31) of TRAIN_SEQUENCE.
  - Cycles with cout_valid_i=0 are not counted.
- Window tracking, per tap:
  - Good tap: the run length increments.
  - Bad tap, or tap 63: close the run.
  - A closed run replaces the best window only if it is strictly longer, so ties keep the earliest window.
  - No wrap from tap 63 to tap 0.
  - After tap 63 go to CENTER; otherwise tap+1 and go to LOAD.
- CENTER:
  - best width 0: err_o=1, go to ERROR.
  - Otherwise: idelay_value_o = eye_start + (width>>1), pulse idelay_load_o, wait SETTLE_CYCLES, go to CHECK.
- CHECK, on the next valid word:
  - word == TRAIN_SEQUENCE: done_o=1, go to DONE.
  - bitslip_count == BITSLIP_MAX: err_o=2, go to ERROR.
  - Otherwise go to SLIP.
- SLIP: pulse bitslip_o for one cycle, bitslip_count+1, wait SETTLE_CYCLES, then CHECK.
- abort_i in any busy state: iserdes_rst_o=0, strobes low, err_o=3, go to ERROR. abort_i has priority over every other transition in the same cycle.
- ERROR and DONE are both idle-equivalent and accept start_i.
- Width rules:
  - The centre sum is computed at 7 bits; it is ≤63 by construction.
  - eye_width_o saturates at 64 (all taps good gives start 0, width 64, centre 32).

## Timing
- start_i sampled at edge N: busy_o=1 and iserdes_rst_o=1 from N+1, held for RST_CYCLES clocks.
- idelay_load_o and bitslip_o are exactly one cycle wide. idelay_value_o is stable from the load cycle until the next load.
- Settle counting begins the cycle after the strobe.
- done_o and err_o update in the same cycle busy_o falls. eye_* are registered when CENTER is entered and stay stable afterward.
- Sweep lower bound: 64 × (1 + SETTLE_CYCLES + SAMPLES valid words).
- sysclk_rst_i mid-operation: all outputs return to 0 on the next edge. No strobe may be extended.

## Test plan
- Pattern model returns TRAIN_SEQUENCE rotated by 5 bits at taps 10–29 and garbage elsewhere; each bitslip rotates by 1 → eye_start=10, width=20, IDELAY parked at 20, 27 bitslips, done_o=1, err_o=0.
- Good runs at taps 3–8 and 40–45 (equal width 6) → eye_start=3, centre 6.
- All taps good → start 0, width 64, centre 32. No good tap → err_o=1, bitslip_o never pulses.
- Stable rotated word but bitslip has no effect → exactly 32 bitslip pulses, then err_o=2, busy_o=0.
- abort_i during SAMPLE at tap 17 → err_o=3 next cycle. A subsequent start_i restarts from tap 0 with RST_CYCLES=16 reset.
- sysclk_rst_i during SLIP_WAIT → all outputs 0. start_i pulses while busy are ignored (no restart, tap counter unchanged).

Source files
------------

// File: rtl/surf_cout_autotrain.sv
// COUT link auto-training sequencer: sweeps the IDELAY for the widest stable eye,
// parks at its centre, then bitslips until the received word matches the training word.
module surf_cout_autotrain #(
   parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
   parameter int          RST_CYCLES     = 16,
   parameter int          SETTLE_CYCLES  = 32,
   parameter int          SAMPLES        = 8,
   parameter int          BITSLIP_MAX    = 32
) (
   input  logic        sysclk_i,
   input  logic        sysclk_rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] cout_data_i,
   input  logic        cout_valid_i,
   output logic        iserdes_rst_o,
   output logic [5:0]  idelay_value_o,
   output logic        idelay_load_o,
   output logic        bitslip_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  err_o,
   output logic [5:0]  eye_start_o,
   output logic [6:0]  eye_width_o,
   output logic [5:0]  bitslip_count_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_RESET, S_LOAD, S_SETTLE, S_SAMPLE, S_CENTER, S_CWAIT,
      S_CHECK, S_SLIP, S_SWAIT, S_DONE, S_ERROR
   } state_t;

   state_t      state_r;
   logic [15:0] cnt_r;
   logic [7:0]  smp_cnt_r;
   logic [5:0]  tap_r;
   logic [31:0] ref_r;
   logic        match_r;
   logic [6:0]  run_len_r;
   logic [5:0]  run_start_r;
   logic [6:0]  best_width_r;
   logic [5:0]  best_start_r;

   logic        busy_state_s;
   logic        settle_done_s;
   logic [31:0] ref_s;
   logic        match_s;
   logic        good_s;
   logic        close_s;
   logic [6:0]  run_len_s;
   logic [5:0]  run_start_s;

   // True when w equals TRAIN_SEQUENCE rotated left by any amount 0..31.
   function automatic logic is_rotation(input logic [31:0] w);
      logic        hit;
      logic [31:0] r;
      hit = 1'b0;
      r   = TRAIN_SEQUENCE;
      for (int i = 0; i < 32; i++) begin
         hit = hit | (r == w);
         r   = {r[30:0], r[31]};
      end
      return hit;
   endfunction

   // Per-sample tap evaluation and run-length bookkeeping for the current word.
   always_comb begin
      busy_state_s  = !(state_r inside {S_IDLE, S_DONE, S_ERROR});
      settle_done_s = (cnt_r == 16'(SETTLE_CYCLES));
      ref_s         = (smp_cnt_r == 8'd0) ? cout_data_i : ref_r;
      match_s       = (smp_cnt_r == 8'd0) ? 1'b1 : (match_r && (cout_data_i == ref_r));
      good_s        = match_s && is_rotation(ref_s);
      close_s       = !good_s || (tap_r == 6'd63);
      run_len_s     = good_s ? (run_len_r + 7'd1) : run_len_r;
      run_start_s   = (good_s && (run_len_r == 7'd0)) ? tap_r : run_start_r;
   end

   // Training state machine with registered outputs.
   always_ff @(posedge sysclk_i) begin
      if (sysclk_rst_i) begin
         state_r         <= S_IDLE;
         cnt_r           <= 16'd0;
         smp_cnt_r       <= 8'd0;
         tap_r           <= 6'd0;
         ref_r           <= 32'd0;
         match_r         <= 1'b0;
         run_len_r       <= 7'd0;
         run_start_r     <= 6'd0;
         best_width_r    <= 7'd0;
         best_start_r    <= 6'd0;
         iserdes_rst_o   <= 1'b0;
         idelay_value_o  <= 6'd0;
         idelay_load_o   <= 1'b0;
         bitslip_o       <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         err_o           <= 2'd0;
         eye_start_o     <= 6'd0;
         eye_width_o     <= 7'd0;
         bitslip_count_o <= 6'd0;
      end else begin
         idelay_load_o <= 1'b0;
         bitslip_o     <= 1'b0;
         if (busy_state_s && abort_i) begin
            iserdes_rst_o <= 1'b0;
            err_o         <= 2'd3;
            busy_o        <= 1'b0;
            state_r       <= S_ERROR;
         end else begin
            case (state_r)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (start_i) begin
                     done_o          <= 1'b0;
                     err_o           <= 2'd0;
                     eye_start_o     <= 6'd0;
                     eye_width_o     <= 7'd0;
                     bitslip_count_o <= 6'd0;
                     tap_r           <= 6'd0;
                     run_len_r       <= 7'd0;
                     run_start_r     <= 6'd0;
                     best_width_r    <= 7'd0;
                     best_start_r    <= 6'd0;
                     smp_cnt_r       <= 8'd0;
                     cnt_r           <= 16'd0;
                     iserdes_rst_o   <= 1'b1;
                     busy_o          <= 1'b1;
                     state_r         <= S_RESET;
                  end else begin
                     state_r <= state_r;
                  end
               end
               S_RESET: begin
                  if (cnt_r == 16'(RST_CYCLES - 1)) begin
                     iserdes_rst_o <= 1'b0;
                     state_r       <= S_LOAD;
                  end else begin
                     cnt_r <= cnt_r + 16'd1;
                  end
               end
               S_LOAD: begin
                  idelay_value_o <= tap_r;
                  idelay_load_o  <= 1'b1;
                  cnt_r          <= 16'd0;
                  state_r        <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (settle_done_s) begin
                     smp_cnt_r <= 8'd0;
                     state_r   <= S_SAMPLE;
                  end else begin
                     cnt_r <= cnt_r + 16'd1;
                  end
               end
               S_SAMPLE: begin
                  if (cout_valid_i) begin
                     ref_r     <= ref_s;
                     match_r   <= match_s;
                     smp_cnt_r <= smp_cnt_r + 8'd1;
                     if (smp_cnt_r == 8'(SAMPLES - 1)) begin
                        // Ties keep the earlier window: only a strictly longer run wins.
                        run_start_r <= run_start_s;
                        run_len_r   <= close_s ? 7'd0 : run_len_s;
                        if (close_s && (run_len_s > best_width_r)) begin
                           best_width_r <= run_len_s;
                           best_start_r <= run_start_s;
                        end else begin
                           best_width_r <= best_width_r;
                        end
                        if (tap_r == 6'd63) begin
                           state_r <= S_CENTER;
                        end else begin
                           tap_r   <= tap_r + 6'd1;
                           state_r <= S_LOAD;
                        end
                     end else begin
                        state_r <= S_SAMPLE;
                     end
                  end else begin
                     state_r <= S_SAMPLE;
                  end
               end
               S_CENTER: begin
                  eye_start_o <= best_start_r;
                  eye_width_o <= best_width_r;
                  if (best_width_r == 7'd0) begin
                     err_o   <= 2'd1;
                     busy_o  <= 1'b0;
                     state_r <= S_ERROR;
                  end else begin
                     idelay_value_o <= best_start_r + best_width_r[6:1];
                     idelay_load_o  <= 1'b1;
                     cnt_r          <= 16'd0;
                     state_r        <= S_CWAIT;
                  end
               end
               S_CWAIT, S_SWAIT: begin
                  if (settle_done_s) begin
                     state_r <= S_CHECK;
                  end else begin
                     cnt_r <= cnt_r + 16'd1;
                  end
               end
               S_CHECK: begin
                  if (!cout_valid_i) begin
                     state_r <= S_CHECK;
                  end else if (cout_data_i == TRAIN_SEQUENCE) begin
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                     state_r <= S_DONE;
                  end else if (bitslip_count_o == 6'(BITSLIP_MAX)) begin
                     err_o   <= 2'd2;
                     busy_o  <= 1'b0;
                     state_r <= S_ERROR;
                  end else begin
                     state_r <= S_SLIP;
                  end
               end
               S_SLIP: begin
                  bitslip_o       <= 1'b1;
                  bitslip_count_o <= bitslip_count_o + 6'd1;
                  cnt_r           <= 16'd0;
                  state_r         <= S_SWAIT;
               end
               default: begin
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
